// File: rtl/control_module_pkg.sv
// rtl/control_module_pkg.sv - shared opcodes, T-states and control-word bit map for the sequencer
package control_module_pkg;

   localparam int OPW   = 4;
   localparam int STEPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [STEPW-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   localparam int CW_W       = 16;
   localparam int CW_HLT     = 15;
   localparam int CW_CO      = 14;
   localparam int CW_CE      = 13;
   localparam int CW_J       = 12;
   localparam int CW_MI      = 11;
   localparam int CW_RI      = 10;
   localparam int CW_RO      = 9;
   localparam int CW_II      = 8;
   localparam int CW_IO      = 7;
   localparam int CW_AI      = 6;
   localparam int CW_AO      = 5;
   localparam int CW_BI      = 4;
   localparam int CW_ALU_OE  = 3;
   localparam int CW_ALU_SUB = 2;
   localparam int CW_ALU_IE  = 1;
   localparam int CW_OI      = 0;

   typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/control_module_ctrl_rom.sv
// rtl/control_module_ctrl_rom.sv - combinational microcode decode of step, opcode and flags
module control_module_ctrl_rom
   import control_module_pkg::*;
(
   input  logic [STEPW-1:0] step,
   input  logic [OPW-1:0]   opcode,
   input  logic             zf,
   input  logic             cf,
   output logic [CW_W-1:0]  cw,
   output logic             last_step
);

   always_comb begin
      cw        = '0;
      last_step = 1'b0;
      case (step)
         T0: begin
            cw[CW_CO] = 1'b1;
            cw[CW_MI] = 1'b1;
         end
         T1: begin
            cw[CW_RO] = 1'b1;
            cw[CW_II] = 1'b1;
            cw[CW_CE] = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
               OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 1'b0;
               default:                              last_step = 1'b1;
            endcase
         end
         T2: begin
            // Flags only steer the jump here; other steps never look at them.
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw[CW_IO] = 1'b1;
                  cw[CW_MI] = 1'b1;
               end
               OP_LDI: begin
                  cw[CW_IO] = 1'b1;
                  cw[CW_AI] = 1'b1;
                  last_step = 1'b1;
               end
               OP_JMP: begin
                  cw[CW_IO] = 1'b1;
                  cw[CW_J]  = 1'b1;
                  last_step = 1'b1;
               end
               OP_JC: begin
                  cw[CW_IO] = 1'b1;
                  cw[CW_J]  = cf;
                  last_step = 1'b1;
               end
               OP_JZ: begin
                  cw[CW_IO] = 1'b1;
                  cw[CW_J]  = zf;
                  last_step = 1'b1;
               end
               OP_OUT: begin
                  cw[CW_AO] = 1'b1;
                  cw[CW_OI] = 1'b1;
                  last_step = 1'b1;
               end
               OP_HLT:  cw[CW_HLT] = 1'b1;
               default: last_step  = 1'b1;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  cw[CW_RO] = 1'b1;
                  cw[CW_AI] = 1'b1;
                  last_step = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw[CW_RO]      = 1'b1;
                  cw[CW_BI]      = 1'b1;
                  cw[CW_ALU_SUB] = (opcode == OP_SUB);
               end
               OP_STA: begin
                  cw[CW_AO] = 1'b1;
                  cw[CW_RI] = 1'b1;
                  last_step = 1'b1;
               end
               default: last_step = 1'b1;
            endcase
         end
         T4: begin
            last_step = 1'b1;
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               cw[CW_ALU_OE]  = 1'b1;
               cw[CW_AI]      = 1'b1;
               cw[CW_ALU_IE]  = 1'b1;
               cw[CW_ALU_SUB] = (opcode == OP_SUB);
            end
         end
         default: last_step = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_module.sv
// rtl/control_module.sv - falling-edge step sequencer with halt latch and reset-gated control outputs
module control_module
   import control_module_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [OPW-1:0]   opcode,
   input  logic             zf,
   input  logic             cf,
   output logic             hlt,
   output logic             co,
   output logic             ce,
   output logic             j,
   output logic             mi,
   output logic             ri,
   output logic             ro,
   output logic             ii,
   output logic             io,
   output logic             ai,
   output logic             ao,
   output logic             bi,
   output logic             alu_oe,
   output logic             alu_sub,
   output logic             alu_ie,
   output logic             oi,
   output logic [STEPW-1:0] step
);

   logic [STEPW-1:0] step_q;
   logic             halted;
   logic [CW_W-1:0]  rom_cw;
   logic             last_step;
   logic [CW_W-1:0]  cw;

   control_module_ctrl_rom u_rom (
      .step      (step_q),
      .opcode    (opcode),
      .zf        (zf),
      .cf        (cf),
      .cw        (rom_cw),
      .last_step (last_step)
   );

   // Falling-edge update keeps the control word stable across the rising edge where registers latch.
   always_ff @(negedge clk) begin
      if (rst) begin
         step_q <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         if (step_q == T2 && opcode == OP_HLT)
            halted <= 1'b1;
         else if (last_step)
            step_q <= T0;
         else
            step_q <= step_q + STEPW'(1);
      end
   end

   always_comb begin
      cw = '0;
      if (!rst) begin
         if (halted)
            cw[CW_HLT] = 1'b1;
         else
            cw = rom_cw;
      end
   end

   assign hlt     = cw[CW_HLT];
   assign co      = cw[CW_CO];
   assign ce      = cw[CW_CE];
   assign j       = cw[CW_J];
   assign mi      = cw[CW_MI];
   assign ri      = cw[CW_RI];
   assign ro      = cw[CW_RO];
   assign ii      = cw[CW_II];
   assign io      = cw[CW_IO];
   assign ai      = cw[CW_AI];
   assign ao      = cw[CW_AO];
   assign bi      = cw[CW_BI];
   assign alu_oe  = cw[CW_ALU_OE];
   assign alu_sub = cw[CW_ALU_SUB];
   assign alu_ie  = cw[CW_ALU_IE];
   assign oi      = cw[CW_OI];
   assign step    = step_q;

endmodule

// File: tb/tb_control_module.sv
// tb/tb_control_module.sv - scoreboard bench for the control_module sequencer
module tb_control_module;
   import control_module_pkg::*;

   logic             clk;
   logic             rst;
   logic [OPW-1:0]   opcode;
   logic             zf;
   logic             cf;
   logic             hlt, co, ce, j, mi, ri, ro, ii, io, ai, ao, bi;
   logic             alu_oe, alu_sub, alu_ie, oi;
   logic [STEPW-1:0] step;

   control_module dut (
      .clk     (clk),
      .rst     (rst),
      .opcode  (opcode),
      .zf      (zf),
      .cf      (cf),
      .hlt     (hlt),
      .co      (co),
      .ce      (ce),
      .j       (j),
      .mi      (mi),
      .ri      (ri),
      .ro      (ro),
      .ii      (ii),
      .io      (io),
      .ai      (ai),
      .ao      (ao),
      .bi      (bi),
      .alu_oe  (alu_oe),
      .alu_sub (alu_sub),
      .alu_ie  (alu_ie),
      .oi      (oi),
      .step    (step)
   );

   localparam cw_t M_HLT = cw_t'(1) << CW_HLT;
   localparam cw_t M_CO  = cw_t'(1) << CW_CO;
   localparam cw_t M_CE  = cw_t'(1) << CW_CE;
   localparam cw_t M_J   = cw_t'(1) << CW_J;
   localparam cw_t M_MI  = cw_t'(1) << CW_MI;
   localparam cw_t M_RI  = cw_t'(1) << CW_RI;
   localparam cw_t M_RO  = cw_t'(1) << CW_RO;
   localparam cw_t M_II  = cw_t'(1) << CW_II;
   localparam cw_t M_IO  = cw_t'(1) << CW_IO;
   localparam cw_t M_AI  = cw_t'(1) << CW_AI;
   localparam cw_t M_AO  = cw_t'(1) << CW_AO;
   localparam cw_t M_BI  = cw_t'(1) << CW_BI;
   localparam cw_t M_AOE = cw_t'(1) << CW_ALU_OE;
   localparam cw_t M_SUB = cw_t'(1) << CW_ALU_SUB;
   localparam cw_t M_AIE = cw_t'(1) << CW_ALU_IE;
   localparam cw_t M_OI  = cw_t'(1) << CW_OI;

   localparam cw_t F0 = M_CO | M_MI;
   localparam cw_t F1 = M_RO | M_II | M_CE;

   typedef struct packed {
      logic [STEPW-1:0] st;
      cw_t              cw;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   cw_t  obs_cw;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always_comb begin
      obs_cw             = '0;
      obs_cw[CW_HLT]     = hlt;
      obs_cw[CW_CO]      = co;
      obs_cw[CW_CE]      = ce;
      obs_cw[CW_J]       = j;
      obs_cw[CW_MI]      = mi;
      obs_cw[CW_RI]      = ri;
      obs_cw[CW_RO]      = ro;
      obs_cw[CW_II]      = ii;
      obs_cw[CW_IO]      = io;
      obs_cw[CW_AI]      = ai;
      obs_cw[CW_AO]      = ao;
      obs_cw[CW_BI]      = bi;
      obs_cw[CW_ALU_OE]  = alu_oe;
      obs_cw[CW_ALU_SUB] = alu_sub;
      obs_cw[CW_ALU_IE]  = alu_ie;
      obs_cw[CW_OI]      = oi;
   end

   // Step updates on the falling edge, so outputs are sampled on the rising edge.
   always @(posedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("step", 32'(step), 32'(e.st));
         chk("ctrl", 32'(obs_cw), 32'(e.cw));
         chk("bus_one_driver", 32'($countones({co, ro, io, ao, alu_oe}) <= 1), 32'd1);
      end
   end

   task automatic cyc(input logic r, input logic [OPW-1:0] op, input logic z, input logic c,
                      input int es, input cw_t ecw);
      exp_t e;
      @(negedge clk);
      #1;
      rst    = r;
      opcode = op;
      zf     = z;
      cf     = c;
      e.st   = STEPW'(es);
      e.cw   = ecw;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic [OPW-1:0] op, input logic z, input logic c);
      cyc(1'b0, op, z, c, 0, F0);
      cyc(1'b0, op, z, c, 1, F1);
   endtask

   initial begin
      rst    = 1'b1;
      opcode = OP_ADD;
      zf     = 1'b0;
      cf     = 1'b0;

      cyc(1'b1, OP_ADD, 1'b0, 1'b0, 0, '0);
      cyc(1'b1, OP_ADD, 1'b0, 1'b0, 0, '0);

      fetch(OP_LDA, 1'b0, 1'b0);
      cyc(1'b0, OP_LDA, 1'b0, 1'b0, 2, M_IO | M_MI);
      cyc(1'b0, OP_LDA, 1'b1, 1'b1, 3, M_RO | M_AI);

      fetch(OP_ADD, 1'b0, 1'b0);
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, 2, M_IO | M_MI);
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, 3, M_RO | M_BI);
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, 4, M_AOE | M_AI | M_AIE);

      fetch(OP_SUB, 1'b0, 1'b0);
      cyc(1'b0, OP_SUB, 1'b0, 1'b0, 2, M_IO | M_MI);
      cyc(1'b0, OP_SUB, 1'b0, 1'b0, 3, M_RO | M_BI | M_SUB);
      cyc(1'b0, OP_SUB, 1'b0, 1'b0, 4, M_AOE | M_AI | M_AIE | M_SUB);

      fetch(OP_STA, 1'b0, 1'b0);
      cyc(1'b0, OP_STA, 1'b0, 1'b0, 2, M_IO | M_MI);
      cyc(1'b0, OP_STA, 1'b0, 1'b0, 3, M_AO | M_RI);

      fetch(OP_LDI, 1'b0, 1'b0);
      cyc(1'b0, OP_LDI, 1'b0, 1'b0, 2, M_IO | M_AI);

      fetch(OP_JMP, 1'b0, 1'b0);
      cyc(1'b0, OP_JMP, 1'b0, 1'b0, 2, M_IO | M_J);

      fetch(OP_JC, 1'b0, 1'b0);
      cyc(1'b0, OP_JC, 1'b0, 1'b0, 2, M_IO);
      fetch(OP_JC, 1'b0, 1'b0);
      cyc(1'b0, OP_JC, 1'b0, 1'b1, 2, M_IO | M_J);
      fetch(OP_JC, 1'b0, 1'b1);
      cyc(1'b0, OP_JC, 1'b0, 1'b0, 2, M_IO);

      fetch(OP_JZ, 1'b0, 1'b0);
      cyc(1'b0, OP_JZ, 1'b1, 1'b0, 2, M_IO | M_J);
      fetch(OP_JZ, 1'b1, 1'b1);
      cyc(1'b0, OP_JZ, 1'b0, 1'b1, 2, M_IO);

      fetch(OP_OUT, 1'b0, 1'b0);
      cyc(1'b0, OP_OUT, 1'b0, 1'b0, 2, M_AO | M_OI);

      fetch(OP_NOP, 1'b0, 1'b0);
      fetch(4'hA, 1'b1, 1'b1);
      fetch(4'hD, 1'b0, 1'b0);

      fetch(OP_HLT, 1'b0, 1'b0);
      cyc(1'b0, OP_HLT, 1'b0, 1'b0, 2, M_HLT);
      for (int k = 0; k < 10; k++)
         cyc(1'b0, OP_LDI, k[0], k[1], 2, M_HLT);
      cyc(1'b1, OP_LDI, 1'b0, 1'b0, 2, '0);
      fetch(OP_NOP, 1'b0, 1'b0);

      fetch(OP_ADD, 1'b0, 1'b0);
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, 2, M_IO | M_MI);
      cyc(1'b1, OP_ADD, 1'b0, 1'b0, 3, '0);
      fetch(4'hA, 1'b0, 1'b0);
      fetch(4'hA, 1'b0, 1'b0);
      fetch(OP_LDA, 1'b0, 1'b0);

      @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
